vc_rr_arbiter: RTL and testbench

Downstream consumer of four class FIFOs (10-bit words, depth 8) in the adaptive PCIe switch datapath. Each cycle it picks one non-empty FIFO in round-robin order, pops it, and pushes the word into a single downstream FIFO one cycle later. It honours downstream back-pressure (almost_full / pause), aggregates FIFO error flags, and keeps per-input word counters for verification.

---
 rtl/vc_rr_arbiter_pkg.sv | 25 ++
 rtl/vc_rr_arbiter_rr_pick4.sv | 37 +++
 rtl/vc_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_vc_rr_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/vc_rr_arbiter_pkg.sv
// vc_rr_arbiter_pkg
// Shared definitions for the class-FIFO round-robin arbiter slice:
// datapath widths, the arbiter state encoding and a one-hot helper.
package vc_rr_arbiter_pkg;

    localparam int DATA_SIZE = 10;  // word width of all FIFO data
    localparam int NUM_IN    = 4;   // upstream FIFO count (grant index is 2 bits)
    localparam int COUNT_W   = 8;   // per-input pop counter width
    localparam int GRANT_W   = 2;   // width of a grant index

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } arb_state_e;

    // Convert a grant index into the one-hot pop strobe pattern.
    function automatic logic [NUM_IN-1:0] idx_to_onehot(input logic [GRANT_W-1:0] idx);
        logic [NUM_IN-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/vc_rr_arbiter_rr_pick4.sv
// rr_pick4
// Combinational 4-way round-robin priority picker. The search starts one
// position above last_grant and wraps, so the previous winner has the
// lowest priority.
// Ports:
//   eligible    in  [3:0]  request vector
//   last_grant  in  [1:0]  index of the previous winner
//   grant_valid out        some input was eligible
//   grant_idx   out [1:0]  winning index (last_grant when none)
module rr_pick4
    import vc_rr_arbiter_pkg::*;
(
    input  logic [3:0]         eligible,
    input  logic [GRANT_W-1:0] last_grant,
    output logic               grant_valid,
    output logic [GRANT_W-1:0] grant_idx
);

    logic [GRANT_W-1:0] cand_s;

    // Walk offsets 1..4 from last_grant; the first eligible candidate wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        cand_s      = last_grant;
        for (int k = 1; k <= 4; k++) begin
            cand_s = last_grant + GRANT_W'(k);
            if (!grant_valid && eligible[cand_s]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_s;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter
// Pops four upstream class FIFOs in round-robin order and forwards each
// popped word to one downstream FIFO a cycle later, honouring downstream
// back-pressure, collecting error flags and counting pops per input.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   fifo_empty/error    per-FIFO status from the upstream FIFOs
//   data_out_pop        upstream words, FIFO i at [i*DATA_SIZE +: DATA_SIZE]
//   read                registered one-hot pop strobe
//   down_almost_full    downstream pause request
//   down_error          downstream error flag
//   write/data_in_push  downstream push strobe and word
//   arb_state           current state (debug)
//   arb_error           sticky error flag
//   cnt_sel/cnt_out     pop counter readback
module vc_rr_arbiter
    import vc_rr_arbiter_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IN-1:0]           fifo_empty,
    input  logic [NUM_IN-1:0]           fifo_error,
    input  logic [NUM_IN*DATA_SIZE-1:0] data_out_pop,
    output logic [NUM_IN-1:0]           read,
    input  logic                        down_almost_full,
    input  logic                        down_error,
    output logic                        write,
    output logic [DATA_SIZE-1:0]        data_in_push,
    output logic [1:0]                  arb_state,
    output logic                        arb_error,
    input  logic [GRANT_W-1:0]          cnt_sel,
    output logic [COUNT_W-1:0]          cnt_out
);

    arb_state_e          state_q, state_d;
    logic [NUM_IN-1:0]   read_q, read_d;
    logic [GRANT_W-1:0]  last_grant_q, last_grant_d;
    logic                pend_valid_q, pend_valid_d;
    logic [GRANT_W-1:0]  pend_idx_q, pend_idx_d;
    logic [DATA_SIZE-1:0] hold_q, hold_d;
    logic                err_q, err_d;
    logic [COUNT_W-1:0]  cnt_q [NUM_IN];
    logic [COUNT_W-1:0]  cnt_d [NUM_IN];

    logic [NUM_IN-1:0]    eligible_s;
    logic                 grant_valid_s;
    logic [GRANT_W-1:0]   grant_idx_s;
    logic [DATA_SIZE-1:0] pop_word_s;

    // The FIFO being popped right now still shows its stale empty flag,
    // so it sits out one cycle to avoid an underflow.
    assign eligible_s = ~fifo_empty & ~read_q;

    rr_pick4 u_pick (
        .eligible    (eligible_s),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Next-state selection: pause outranks any grant.
    always_comb begin
        state_d = ST_IDLE;
        if (down_almost_full) begin
            state_d = ST_PAUSE;
        end else if (grant_valid_s) begin
            state_d = ST_ACTIVE;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Grant issue: a read is raised only together with entry into ACTIVE.
    always_comb begin
        read_d       = '0;
        last_grant_d = last_grant_q;
        if (state_d == ST_ACTIVE) begin
            read_d       = idx_to_onehot(grant_idx_s);
            last_grant_d = grant_idx_s;
        end else begin
            read_d       = '0;
            last_grant_d = last_grant_q;
        end
    end

    // Push path: the word returned for the previous pop is forwarded,
    // otherwise the output keeps the last forwarded word.
    always_comb begin
        pend_valid_d = |read_q;
        pend_idx_d   = last_grant_q;  // equals the index of read_q when it is set
        pop_word_s   = data_out_pop[pend_idx_q*DATA_SIZE +: DATA_SIZE];
        if (pend_valid_q) begin
            hold_d = pop_word_s;
        end else begin
            hold_d = hold_q;
        end
    end

    // Sticky error and per-input pop counters.
    always_comb begin
        err_d = err_q | (|fifo_error) | down_error | (|(read_q & fifo_empty));
        for (int i = 0; i < NUM_IN; i++) begin
            if (read_q[i]) begin
                cnt_d[i] = cnt_q[i] + COUNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            read_q       <= '0;
            last_grant_q <= GRANT_W'(NUM_IN - 1);
            pend_valid_q <= 1'b0;
            pend_idx_q   <= '0;
            hold_q       <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            last_grant_q <= last_grant_d;
            pend_valid_q <= pend_valid_d;
            pend_idx_q   <= pend_idx_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign read         = read_q;
    assign write        = pend_valid_q;
    assign data_in_push = pend_valid_q ? pop_word_s : hold_q;
    assign arb_state    = state_q;
    assign arb_error    = err_q;
    assign cnt_out      = cnt_q[cnt_sel];

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// tb_vc_rr_arbiter
// Directed table-driven bench for vc_rr_arbiter. Each upstream word is
// {fifo index, 8-bit tag}, so 0x001/0x101/... identify FIFO and word.
module tb_vc_rr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [3:0]  fifo_error;
    logic [39:0] data_out_pop;
    logic [3:0]  read;
    logic        down_almost_full;
    logic        down_error;
    logic        write;
    logic [9:0]  data_in_push;
    logic [1:0]  arb_state;
    logic        arb_error;
    logic [1:0]  cnt_sel;
    logic [7:0]  cnt_out;

    int n_applied = 0;
    int n_miss    = 0;

    typedef struct {
        logic       rst;
        logic [3:0] empty;
        logic [3:0] ferr;
        logic       daf;
        logic       derr;
        logic [7:0] tag;
        logic [3:0] e_read;
        logic       e_write;
        logic [9:0] e_data;
        logic [1:0] e_state;
        logic       e_err;
    } vec_t;

    vec_t vecs[29];

    vc_rr_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_empty       (fifo_empty),
        .fifo_error       (fifo_error),
        .data_out_pop     (data_out_pop),
        .read             (read),
        .down_almost_full (down_almost_full),
        .down_error       (down_error),
        .write            (write),
        .data_in_push     (data_in_push),
        .arb_state        (arb_state),
        .arb_error        (arb_error),
        .cnt_sel          (cnt_sel),
        .cnt_out          (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [3:0] empty, input logic [3:0] ferr,
                                input logic daf, input logic derr, input logic [7:0] tag,
                                input logic [3:0] e_read, input logic e_write, input logic [9:0] e_data,
                                input logic [1:0] e_state, input logic e_err);
        vec_t v;
        v.rst = rst; v.empty = empty; v.ferr = ferr; v.daf = daf; v.derr = derr; v.tag = tag;
        v.e_read = e_read; v.e_write = e_write; v.e_data = e_data; v.e_state = e_state; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic set_tag(input logic [7:0] tag);
        for (int i = 0; i < 4; i++) begin
            data_out_pop[i*10 +: 10] = {2'(i), tag};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops;
        int budget;

        // rst  empty    ferr     daf   derr  tag      read     wr    data      st     err
        vecs[0]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0);
        vecs[1]  = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0);
        // streaming, all FIFOs non-empty: first grant is input 0
        vecs[2]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0001, 1'b0, 10'h000, 2'd1, 1'b0);
        vecs[3]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0010, 1'b1, 10'h001, 2'd1, 1'b0);
        vecs[4]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0100, 1'b1, 10'h101, 2'd1, 1'b0);
        vecs[5]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b1000, 1'b1, 10'h201, 2'd1, 1'b0);
        vecs[6]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0001, 1'b1, 10'h301, 2'd1, 1'b0);
        vecs[7]  = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 4'b0010, 1'b1, 10'h002, 2'd1, 1'b0);
        // pause for 4 cycles: one trailing write, then resume at input 2
        vecs[8]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h02, 4'b0000, 1'b1, 10'h102, 2'd2, 1'b0);
        vecs[9]  = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h02, 4'b0000, 1'b0, 10'h102, 2'd2, 1'b0);
        vecs[10] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h02, 4'b0000, 1'b0, 10'h102, 2'd2, 1'b0);
        vecs[11] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 8'h02, 4'b0000, 1'b0, 10'h102, 2'd2, 1'b0);
        vecs[12] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 4'b0100, 1'b0, 10'h102, 2'd1, 1'b0);
        vecs[13] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 4'b1000, 1'b1, 10'h202, 2'd1, 1'b0);
        // one-cycle fifo_error[1] pulse: sticky error, transfers continue
        vecs[14] = mk(1'b0, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'h02, 4'b0001, 1'b1, 10'h302, 2'd1, 1'b1);
        vecs[15] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h02, 4'b0010, 1'b1, 10'h002, 2'd1, 1'b1);
        // reset with a read in flight: no write afterwards
        vecs[16] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0);
        // only FIFO 2 holds 3 words: reads on alternate cycles
        vecs[17] = mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0100, 1'b0, 10'h000, 2'd1, 1'b0);
        vecs[18] = mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0000, 1'b1, 10'h201, 2'd0, 1'b0);
        vecs[19] = mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h01, 4'b0100, 1'b0, 10'h201, 2'd1, 1'b0);
        vecs[20] = mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h02, 4'b0000, 1'b1, 10'h202, 2'd0, 1'b0);
        vecs[21] = mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h02, 4'b0100, 1'b0, 10'h202, 2'd1, 1'b0);
        vecs[22] = mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0000, 1'b1, 10'h203, 2'd0, 1'b0);
        vecs[23] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0000, 1'b0, 10'h203, 2'd0, 1'b0);
        // FIFO 2 reports empty while being popped: underflow error
        vecs[24] = mk(1'b0, 4'b1011, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0100, 1'b0, 10'h203, 2'd1, 1'b0);
        vecs[25] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0000, 1'b1, 10'h203, 2'd0, 1'b1);
        // downstream error sets the sticky flag
        vecs[26] = mk(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b0);
        vecs[27] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 8'h03, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b1);
        vecs[28] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 8'h03, 4'b0000, 1'b0, 10'h000, 2'd0, 1'b1);

        reset            = 1'b1;
        fifo_empty       = 4'b0000;
        fifo_error       = 4'b0000;
        down_almost_full = 1'b0;
        down_error       = 1'b0;
        cnt_sel          = 2'd0;
        set_tag(8'h01);

        // counters read zero while reset is held with all FIFOs non-empty
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            check("cnt_reset", s, 32'(cnt_out), 32'd0);
        end
        cnt_sel = 2'd0;

        for (int v = 0; v < 29; v++) begin
            reset            = vecs[v].rst;
            fifo_empty       = vecs[v].empty;
            fifo_error       = vecs[v].ferr;
            down_almost_full = vecs[v].daf;
            down_error       = vecs[v].derr;
            set_tag(vecs[v].tag);
            tick();
            check("read",  v, 32'(read),         32'(vecs[v].e_read));
            check("write", v, 32'(write),        32'(vecs[v].e_write));
            check("data",  v, 32'(data_in_push), 32'(vecs[v].e_data));
            check("state", v, 32'(arb_state),    32'(vecs[v].e_state));
            check("error", v, 32'(arb_error),    32'(vecs[v].e_err));
        end

        // 257 pops from FIFO 3: its counter wraps to 1
        reset      = 1'b1;
        fifo_empty = 4'b0111;
        fifo_error = 4'b0000;
        down_error = 1'b0;
        tick();
        reset  = 1'b0;
        pops   = 0;
        budget = 0;
        while (pops < 257 && budget < 2000) begin
            tick();
            budget++;
            if (read == 4'b1000) pops++;
        end
        check("wrap_pops", 0, 32'(pops), 32'd257);
        tick();
        fifo_empty = 4'b1111;
        tick();
        cnt_sel = 2'd3;
        #1;
        check("cnt_wrap3", 0, 32'(cnt_out), 32'd1);
        cnt_sel = 2'd2;
        #1;
        check("cnt_idle2", 0, 32'(cnt_out), 32'd0);
        check("wrap_err", 0, 32'(arb_error), 32'd0);

        // reset while a read is in flight drops the word
        fifo_empty = 4'b0111;
        tick();
        check("inflight_read", 0, 32'(read), 32'(4'b1000));
        reset = 1'b1;
        tick();
        check("rst_write", 0, 32'(write), 32'd0);
        check("rst_read",  0, 32'(read),  32'd0);
        reset      = 1'b0;
        fifo_empty = 4'b1111;
        tick();
        check("post_rst_write", 0, 32'(write), 32'd0);
        cnt_sel = 2'd3;
        #1;
        check("post_rst_cnt", 0, 32'(cnt_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
